// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
// Central stall/flush/freeze sequencer for the 5-stage pipeline. Drives the
// pipeline-register enables and bubble inserts for load-use stalls, branch
// and jump flushes, multi-cycle multiply/divide occupancy of EX, and the
// drain-then-park sequence that follows a halt request.
module pipeline_sequencer #(
  parameter int MUL_CYCLES   = 4,
  parameter int DIV_CYCLES   = 16,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] OpcodeID,
  input  logic [3:0] OpcodeEX,
  input  logic [3:0] FunctionCodeEX,
  input  logic [3:0] SrcReg1ID,
  input  logic [3:0] SrcReg2ID,
  input  logic       UsesSrc1ID,
  input  logic       UsesSrc2ID,
  input  logic [3:0] DestRegEX,
  input  logic       BranchTakenEX,
  input  logic       HaltReq,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IFIDFlush,
  output logic       IDEXWrite,
  output logic       IDEXBubble,
  output logic       EXMEMBubble,
  output logic       MulDivStart,
  output logic       MulDivSel,
  output logic       Halted
);

  // Opcodes and function codes the sequencer decodes
  localparam logic [3:0] OP_ATYPE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_LOADA = 4'b0100;
  localparam logic [3:0] OP_LOADB = 4'b0110;
  localparam logic [3:0] FC_MUL   = 4'b1110;
  localparam logic [3:0] FC_DIV   = 4'b1111;

  // Counter preloads. The start cycle and the release cycle each account
  // for one cycle of EX occupancy, hence the -2 on the mul/div loads.
  localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUSY   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // ---------------------------------------------------------------------
  // Hazard decode (only meaningful while in RUN)
  // ---------------------------------------------------------------------
  logic [3:0] w_src_reg [2];
  logic [1:0] w_src_use;
  logic [1:0] w_src_hit;

  assign w_src_reg[0] = SrcReg1ID;
  assign w_src_reg[1] = SrcReg2ID;
  assign w_src_use    = {UsesSrc2ID, UsesSrc1ID};

  // One comparator per ID source operand; register 0 is compared like any other
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src_hit
      assign w_src_hit[gi] = w_src_use[gi] && (w_src_reg[gi] == DestRegEX);
    end
  endgenerate

  logic w_is_load_ex;
  logic w_is_muldiv_ex;
  logic w_load_use;
  logic w_jump_id;

  assign w_is_load_ex   = (OpcodeEX == OP_LOADA) || (OpcodeEX == OP_LOADB);
  assign w_is_muldiv_ex = (OpcodeEX == OP_ATYPE) &&
                          ((FunctionCodeEX == FC_MUL) || (FunctionCodeEX == FC_DIV));
  assign w_load_use     = w_is_load_ex && (|w_src_hit);
  assign w_jump_id      = (OpcodeID == OP_JUMP);

  // Priority-resolved RUN events: exactly one (or none) is active
  logic w_run_branch;
  logic w_run_muldiv;
  logic w_run_loaduse;
  logic w_run_halt;
  logic w_run_jump;

  assign w_run_branch  = BranchTakenEX;
  assign w_run_muldiv  = !w_run_branch && w_is_muldiv_ex;
  assign w_run_loaduse = !w_run_branch && !w_is_muldiv_ex && w_load_use;
  assign w_run_halt    = !w_run_branch && !w_is_muldiv_ex && !w_load_use && HaltReq;
  assign w_run_jump    = !w_run_branch && !w_is_muldiv_ex && !w_load_use && !HaltReq &&
                         w_jump_id;

  logic w_cnt_zero;
  assign w_cnt_zero = (r_cnt == CNT_ZERO);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State and counter register; reset returns to RUN from any state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and counter update
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_run_muldiv) begin
          w_state_next = ST_BUSY;
          w_cnt_next   = FunctionCodeEX[0] ? DIV_LOAD : MUL_LOAD;
        end else if (w_run_halt) begin
          w_state_next = ST_DRAIN;
          w_cnt_next   = DRAIN_LOAD;
        end
      end
      ST_BUSY: begin
        // On release the mul/div instruction leaves EX on this edge, so RUN
        // sees the next instruction and cannot restart the same operation.
        if (w_cnt_zero) begin
          w_state_next = ST_RUN;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      ST_DRAIN: begin
        if (w_cnt_zero) begin
          w_state_next = ST_HALTED;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      ST_HALTED: begin
        w_state_next = ST_HALTED;
      end
      default: begin
        w_state_next = ST_RUN;
        w_cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from state and current inputs; reset overrides everything
  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXWrite   = 1'b1;
    IDEXBubble  = 1'b0;
    EXMEMBubble = 1'b0;
    MulDivStart = 1'b0;
    MulDivSel   = 1'b0;
    Halted      = 1'b0;
    if (rst) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IFIDFlush   = 1'b1;
      IDEXBubble  = 1'b1;
      EXMEMBubble = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_run_branch) begin
            // Squash both younger instructions, whatever they are
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
          end else if (w_run_muldiv) begin
            MulDivStart = 1'b1;
            MulDivSel   = FunctionCodeEX[0];
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMBubble = 1'b1;
          end else if (w_run_loaduse) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
          end else if (w_run_halt) begin
            // The halting instruction is held in ID and not advanced
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
          end else if (w_run_jump) begin
            IFIDFlush = 1'b1;
          end
        end
        ST_BUSY: begin
          // Freeze front end and EX while the unit works; release uses defaults
          if (!w_cnt_zero) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMBubble = 1'b1;
          end
        end
        ST_DRAIN: begin
          // Front end held, older instructions in EX/MEM/WB retire
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
        end
        ST_HALTED: begin
          Halted      = 1'b1;
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEXWrite   = 1'b0;
          IDEXBubble  = 1'b1;
          EXMEMBubble = 1'b1;
        end
        default: begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer
// Directed-vector bench for pipeline_sequencer. Inputs change on the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_pipeline_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] OpcodeID;
  logic [3:0] OpcodeEX;
  logic [3:0] FunctionCodeEX;
  logic [3:0] SrcReg1ID;
  logic [3:0] SrcReg2ID;
  logic       UsesSrc1ID;
  logic       UsesSrc2ID;
  logic [3:0] DestRegEX;
  logic       BranchTakenEX;
  logic       HaltReq;
  logic       PCWrite;
  logic       IFIDWrite;
  logic       IFIDFlush;
  logic       IDEXWrite;
  logic       IDEXBubble;
  logic       EXMEMBubble;
  logic       MulDivStart;
  logic       MulDivSel;
  logic       Halted;

  int n_checks;
  int n_errors;

  pipeline_sequencer #(
    .MUL_CYCLES  (4),
    .DIV_CYCLES  (16),
    .DRAIN_CYCLES(3),
    .CNT_W       (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .OpcodeID      (OpcodeID),
    .OpcodeEX      (OpcodeEX),
    .FunctionCodeEX(FunctionCodeEX),
    .SrcReg1ID     (SrcReg1ID),
    .SrcReg2ID     (SrcReg2ID),
    .UsesSrc1ID    (UsesSrc1ID),
    .UsesSrc2ID    (UsesSrc2ID),
    .DestRegEX     (DestRegEX),
    .BranchTakenEX (BranchTakenEX),
    .HaltReq       (HaltReq),
    .PCWrite       (PCWrite),
    .IFIDWrite     (IFIDWrite),
    .IFIDFlush     (IFIDFlush),
    .IDEXWrite     (IDEXWrite),
    .IDEXBubble    (IDEXBubble),
    .EXMEMBubble   (EXMEMBubble),
    .MulDivStart   (MulDivStart),
    .MulDivSel     (MulDivSel),
    .Halted        (Halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output vector:
  // {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble,
  //  MulDivStart, MulDivSel, Halted}
  // MulDivSel only carries meaning alongside MulDivStart, so it is masked.
  logic [8:0] w_obs;
  assign w_obs = {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble,
                  MulDivStart, MulDivSel & MulDivStart, Halted};

  // Expected output patterns, written out by hand from the behaviour table
  localparam logic [8:0] E_DEF     = 9'b1_1_0_1_0_0_0_0_0;
  localparam logic [8:0] E_RST     = 9'b0_0_1_1_1_1_0_0_0;
  localparam logic [8:0] E_MUL     = 9'b0_0_0_0_0_1_1_0_0;
  localparam logic [8:0] E_DIV     = 9'b0_0_0_0_0_1_1_1_0;
  localparam logic [8:0] E_FREEZE  = 9'b0_0_0_0_0_1_0_0_0;
  localparam logic [8:0] E_STALL   = 9'b0_0_0_1_1_0_0_0_0;
  localparam logic [8:0] E_BRANCH  = 9'b1_1_1_1_1_0_0_0_0;
  localparam logic [8:0] E_JUMP    = 9'b1_1_1_1_0_0_0_0_0;
  localparam logic [8:0] E_HALTED  = 9'b0_0_0_0_1_1_0_0_1;

  // Single comparison point: counts, and reports any mismatch
  task automatic check_out(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end else begin
      $display("ok   %s: %b", tag, obs);
    end
  endtask

  // Sample the outputs for the inputs just driven, then advance one cycle
  task automatic step(input string tag, input logic [8:0] exp);
    #1;
    check_out(tag, w_obs, exp);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    OpcodeID       = 4'b0000;
    OpcodeEX       = 4'b0000;
    FunctionCodeEX = 4'b0000;
    SrcReg1ID      = 4'd0;
    SrcReg2ID      = 4'd0;
    UsesSrc1ID     = 1'b0;
    UsesSrc2ID     = 1'b0;
    DestRegEX      = 4'd0;
    BranchTakenEX  = 1'b0;
    HaltReq        = 1'b0;
  endtask

  task automatic set_muldiv(input logic is_div);
    OpcodeEX       = 4'b0001;
    FunctionCodeEX = is_div ? 4'b1111 : 4'b1110;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);

    // Reset outputs, then defaults in RUN
    step("reset_out", E_RST);
    rst = 1'b0;
    step("run_idle", E_DEF);

    // Load-use via src1: LW R3 in EX, ID reads R3 -> exactly one stall cycle
    OpcodeEX = 4'b0100; DestRegEX = 4'd3; SrcReg1ID = 4'd3; UsesSrc1ID = 1'b1;
    step("loaduse_src1", E_STALL);
    idle_inputs();
    step("loaduse_after", E_DEF);
    // Same match but operand not read -> no stall
    OpcodeEX = 4'b0100; DestRegEX = 4'd3; SrcReg1ID = 4'd3; UsesSrc1ID = 1'b0;
    step("loaduse_unused", E_DEF);
    // Second load opcode, src2, register 0 treated like any other
    idle_inputs();
    OpcodeEX = 4'b0110; DestRegEX = 4'd0; SrcReg2ID = 4'd0; UsesSrc2ID = 1'b1;
    step("loaduse_src2_r0", E_STALL);

    // Branch taken with jump in ID -> flush + bubble, one cycle
    idle_inputs();
    BranchTakenEX = 1'b1; OpcodeID = 4'b0010;
    step("branch_jump", E_BRANCH);
    idle_inputs();
    OpcodeID = 4'b0010;
    step("jump_only", E_JUMP);

    // Branch taken plus halt: halt squashed, no drain
    idle_inputs();
    BranchTakenEX = 1'b1; HaltReq = 1'b1;
    step("branch_halt", E_BRANCH);
    idle_inputs();
    step("branch_halt_nodrain", E_DEF);

    // Load-use plus jump: stall first, flush next cycle
    OpcodeEX = 4'b0100; DestRegEX = 4'd5; SrcReg2ID = 4'd5; UsesSrc2ID = 1'b1;
    OpcodeID = 4'b0010;
    step("loaduse_jump", E_STALL);
    idle_inputs();
    OpcodeID = 4'b0010;
    step("jump_after_stall", E_JUMP);

    // Multiply: start, 2 freeze cycles (halt/jump ignored), release on cycle 4
    idle_inputs();
    set_muldiv(1'b0);
    step("mul_start", E_MUL);
    HaltReq = 1'b1; OpcodeID = 4'b0010;
    step("mul_busy1", E_FREEZE);
    step("mul_busy2", E_FREEZE);
    step("mul_release", E_DEF);
    idle_inputs();
    step("mul_after", E_DEF);

    // Divide interrupted by reset when cnt is 7 (eighth busy cycle)
    set_muldiv(1'b1);
    step("div_start_a", E_DIV);
    for (int k = 1; k <= 7; k++) step($sformatf("div_a_busy%0d", k), E_FREEZE);
    rst = 1'b1;
    step("div_a_reset", E_RST);
    rst = 1'b0;
    idle_inputs();
    step("div_a_after_rst", E_DEF);

    // Full divide with halt requested throughout BUSY: drain only after release
    set_muldiv(1'b1);
    step("div_start_b", E_DIV);
    HaltReq = 1'b1;
    for (int k = 1; k <= 14; k++) step($sformatf("div_b_busy%0d", k), E_FREEZE);
    step("div_b_release", E_DEF);
    OpcodeEX = 4'b0000; FunctionCodeEX = 4'b0000;
    step("halt_entry", E_STALL);
    // Inputs are ignored while draining
    BranchTakenEX = 1'b1; OpcodeID = 4'b0010; set_muldiv(1'b0);
    for (int k = 1; k <= 3; k++) step($sformatf("drain%0d", k), E_STALL);
    for (int k = 1; k <= 22; k++) step($sformatf("halted%0d", k), E_HALTED);
    rst = 1'b1;
    step("halted_reset", E_RST);
    rst = 1'b0;
    idle_inputs();
    step("after_halt_rst", E_DEF);

    // Load-use plus halt: stall first, then halt entry, then drain
    OpcodeEX = 4'b0110; DestRegEX = 4'd9; SrcReg1ID = 4'd9; UsesSrc1ID = 1'b1;
    HaltReq = 1'b1;
    step("loaduse_halt", E_STALL);
    OpcodeEX = 4'b0000;
    step("halt_after_stall", E_STALL);
    idle_inputs();
    step("drain_after_stall", E_STALL);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Central stall/flush/freeze sequencer for the 5-stage pipeline. It sits beside the opcode-driven control unit and drives the pipeline-register enables and bubble inserts. It handles load-use stalls, taken-branch and jump flushes, and multi-cycle multiply/divide occupancy of EX. It also drains the pipeline on a halt request and then parks the machine in HALTED.

Parameters:
MUL_CYCLES, 4, EX occupancy of multiply in cycles (>=2)
DIV_CYCLES, 16, EX occupancy of divide in cycles (>=2)
DRAIN_CYCLES, 3, cycles to retire EX/MEM/WB before HALTED (>=1)
CNT_W, 5, counter width; must hold max(MUL_CYCLES, DIV_CYCLES, DRAIN_CYCLES)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous and active-high
OpcodeID  in  4  opcode of instruction in ID
OpcodeEX  in  4  opcode of instruction in EX
FunctionCodeEX  in  4  A-type function code in EX (1110 = multiply, 1111 = divide)
SrcReg1ID, SrcReg2ID  in  4 each  source register numbers in ID
UsesSrc1ID, UsesSrc2ID  in  1 each  ID instruction reads that source
DestRegEX  in  4  destination register of instruction in EX
BranchTakenEX  in  1  branch in EX resolved taken
HaltReq  in  1  Halt from control unit (undefined opcode or overflow)
PCWrite  out  1  PC load enable
IFIDWrite  out  1  IF/ID enable
IFIDFlush  out  1  clear IF/ID to NOP
IDEXWrite  out  1  ID/EX enable
IDEXBubble  out  1  load NOP into ID/EX
EXMEMBubble  out  1  load NOP into EX/MEM
MulDivStart  out  1  one-cycle start pulse to mul/div unit
MulDivSel  out  1  0 = multiply, 1 = divide; valid with MulDivStart
Halted  out  1  machine parked

Behaviour:
- States: RUN, BUSY, DRAIN, HALTED. Plus CNT_W-bit counter cnt.
- Outputs are combinational from state and inputs.
- Default output set: PCWrite=1, IFIDWrite=1, IDEXWrite=1, all other outputs 0.
- Reset, any state including mid-BUSY or mid-DRAIN:
  - next state RUN, cnt=0.
  - While rst=1, outputs are PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1, EXMEMBubble=1, MulDivStart=0, Halted=0.
- RUN: the first matching condition in this priority order applies.
  1. BranchTakenEX=1 -> IFIDFlush=1, IDEXBubble=1 (squashes ID and IF even if they hold halt or jump). Stay RUN.
  2. OpcodeEX=0001 and FunctionCodeEX in {1110,1111} -> MulDivStart=1, MulDivSel=FunctionCodeEX[0].
     - Freeze: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMBubble=1.
     - cnt <= (MUL_CYCLES or DIV_CYCLES)-2. Next state BUSY.
  3. Load-use: OpcodeEX in {0100,0110}, and DestRegEX matches SrcReg1ID with UsesSrc1ID=1 or SrcReg2ID with UsesSrc2ID=1 -> PCWrite=0, IFIDWrite=0, IDEXBubble=1, for exactly one cycle. Register 0 is not special.
  4. HaltReq=1 -> PCWrite=0, IFIDWrite=0, IDEXBubble=1 (halting instruction does not advance). cnt <= DRAIN_CYCLES-1. Next state DRAIN.
  5. OpcodeID=0010 (jump) -> IFIDFlush=1. PC redirect is handled elsewhere.
- BUSY:
  - cnt!=0 -> same freeze as RUN case 2 (without MulDivStart), cnt decrements.
  - cnt==0 -> release: default outputs, so the result enters EX/MEM. Next state RUN.
  - Total EX occupancy is exactly MUL_CYCLES or DIV_CYCLES cycles.
  - Mul/div result must be valid in the release cycle.
  - HaltReq and jump in ID are ignored during BUSY; they are re-evaluated in RUN.
- DRAIN:
  - PCWrite=0, IFIDWrite=0, IDEXBubble=1. EX/MEM/WB continue, so older instructions retire.
  - Inputs other than rst are ignored.
  - cnt decrements; at cnt==0 next state HALTED.
- HALTED:
  - Halted=1, PCWrite=0, IFIDWrite=0, IDEXWrite=0, IDEXBubble=1, EXMEMBubble=1.
  - Held until rst.
- Simultaneous events:
  - Load-use plus jump in ID: stall wins; jump flush occurs the next cycle.
  - Load-use plus HaltReq: stall first, halt on the following cycle.
  - Branch taken plus HaltReq: branch wins, halt is squashed.
- Re-trigger guard: an instruction released from BUSY has left EX on that edge, so it cannot restart.

Test Plan:
- Load-use: LW R3 in EX, ID reads R3 (UsesSrc1ID=1) -> exactly 1 cycle of PCWrite=0/IFIDWrite=0/IDEXBubble=1, then defaults. With UsesSrc1ID=0 -> no stall.
- Multiply: OpcodeEX=0001, FunctionCodeEX=1110, MUL_CYCLES=4 -> MulDivStart=1 for one cycle with MulDivSel=0, EXMEMBubble=1 for 3 cycles, release on cycle 4. Divide with DIV_CYCLES=16 -> 15 bubble cycles, MulDivSel=1.
- Branch and jump: BranchTakenEX=1 with OpcodeID=0010 -> IFIDFlush=1, IDEXBubble=1 for one cycle. Jump alone -> IFIDFlush=1 only.
- Halt: HaltReq=1 in RUN, DRAIN_CYCLES=3 -> 3 cycles of IDEXBubble=1 with IDEXWrite=1, then Halted=1 held for 20+ cycles until rst.
- Priority: HaltReq=1 with BranchTakenEX=1 -> no DRAIN entry, flush only. HaltReq=1 during BUSY -> DRAIN entered only after release.
- Reset mid-operation: rst=1 at BUSY cnt=7 and again in HALTED -> next cycle RUN, Halted=0, no MulDivStart, defaults after rst deasserts.
